// File: rtl/k_and_s_mem_arbiter.sv
// Two-requester (CPU / debug) arbiter for the shared single-port program/data RAM.
// Define ARB_ROUND_ROBIN_EN for round-robin conflict resolution instead of fixed priority with starvation guard.
`timescale 1ns/1ps
module k_and_s_mem_arbiter #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACC_CPU = 2'd1,
      ACC_DBG = 2'd2
   } state_t;

   localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
   localparam logic             LAST_CPU   = 1'b0;
   localparam logic             LAST_DBG   = 1'b1;

   state_t           state_r, state_s;
   logic [CNT_W-1:0] starve_cnt_r, starve_cnt_s;
   logic             last_gnt_r, last_gnt_s;
   logic             cpu_win_s, dbg_win_s;

   // Both read ports see the RAM directly; rvalid alone says whose data it is.
   assign cpu_rdata = ram_rdata;
   assign dbg_rdata = ram_rdata;

   // Arbitration decision and next-state logic; requests only matter in IDLE.
   always_comb begin
      cpu_win_s    = 1'b0;
      dbg_win_s    = 1'b0;
      state_s      = state_r;
      starve_cnt_s = starve_cnt_r;
      last_gnt_s   = last_gnt_r;
      case (state_r)
         IDLE: begin
            if (cpu_req && dbg_req) begin
`ifdef ARB_ROUND_ROBIN_EN
               if (last_gnt_r == LAST_CPU) begin
                  dbg_win_s = 1'b1;
               end else begin
                  cpu_win_s = 1'b1;
               end
`else
               if (starve_cnt_r == STARVE_LIM) begin
                  dbg_win_s = 1'b1;
               end else begin
                  cpu_win_s = 1'b1;
               end
`endif
            end else if (cpu_req) begin
               cpu_win_s = 1'b1;
            end else if (dbg_req) begin
               dbg_win_s = 1'b1;
            end else begin
               cpu_win_s = 1'b0;
            end

            if (cpu_win_s) begin
               state_s    = ACC_CPU;
               last_gnt_s = LAST_CPU;
            end else if (dbg_win_s) begin
               state_s    = ACC_DBG;
               last_gnt_s = LAST_DBG;
            end else begin
               state_s = IDLE;
            end

`ifdef ARB_ROUND_ROBIN_EN
            starve_cnt_s = {CNT_W{1'b0}};
`else
            // Count only decisions dbg actually lost; saturate so the force-win holds.
            if (dbg_win_s || !dbg_req) begin
               starve_cnt_s = {CNT_W{1'b0}};
            end else if (starve_cnt_r != STARVE_LIM) begin
               starve_cnt_s = starve_cnt_r + CNT_W'(1);
            end else begin
               starve_cnt_s = starve_cnt_r;
            end
`endif
         end
         ACC_CPU, ACC_DBG: state_s = IDLE;
         default:          state_s = IDLE;
      endcase
   end

   // State, arbitration history and registered RAM-side / handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         starve_cnt_r <= {CNT_W{1'b0}};
         last_gnt_r   <= LAST_CPU;
         cpu_gnt      <= 1'b0;
         dbg_gnt      <= 1'b0;
         cpu_rvalid   <= 1'b0;
         dbg_rvalid   <= 1'b0;
         ram_we       <= 1'b0;
         ram_addr     <= {ADDR_W{1'b0}};
         ram_wdata    <= {DATA_W{1'b0}};
      end else begin
         state_r      <= state_s;
         starve_cnt_r <= starve_cnt_s;
         last_gnt_r   <= last_gnt_s;
         cpu_gnt      <= cpu_win_s;
         dbg_gnt      <= dbg_win_s;
         // ram_we is the winner's we during ACC_x, so !ram_we marks a read.
         cpu_rvalid   <= (state_r == ACC_CPU) && !ram_we;
         dbg_rvalid   <= (state_r == ACC_DBG) && !ram_we;
         if (cpu_win_s) begin
            ram_addr  <= cpu_addr;
            ram_wdata <= cpu_wdata;
            ram_we    <= cpu_we;
         end else if (dbg_win_s) begin
            ram_addr  <= dbg_addr;
            ram_wdata <= dbg_wdata;
            ram_we    <= dbg_we;
         end else begin
            ram_we    <= 1'b0;
         end
      end
   end

   k_and_s_mem_arbiter_chk u_chk (
      .clk     (clk),
      .rst_n   (rst_n),
      .cpu_req (cpu_req),
      .cpu_gnt (cpu_gnt),
      .dbg_req (dbg_req),
      .dbg_gnt (dbg_gnt)
   );

endmodule

// Protocol checker: a requester must hold req from first assertion until its gnt.
module k_and_s_mem_arbiter_chk (
   input logic clk,
   input logic rst_n,
   input logic cpu_req,
   input logic cpu_gnt,
   input logic dbg_req,
   input logic dbg_gnt
);

   logic cpu_pend_r, dbg_pend_r;

   // Tracks a request that has been raised but not yet granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_pend_r <= 1'b0;
         dbg_pend_r <= 1'b0;
      end else begin
         cpu_pend_r <= (cpu_pend_r | cpu_req) & ~cpu_gnt;
         dbg_pend_r <= (dbg_pend_r | dbg_req) & ~dbg_gnt;
      end
   end

   a_cpu_req_held: assert property (@(posedge clk) disable iff (!rst_n)
      (cpu_pend_r && !cpu_gnt) |-> cpu_req);
   a_dbg_req_held: assert property (@(posedge clk) disable iff (!rst_n)
      (dbg_pend_r && !dbg_gnt) |-> dbg_req);

endmodule

// File: tb/tb_k_and_s_mem_arbiter.sv
// Self-checking bench for k_and_s_mem_arbiter: vector table of single accesses with a
// read-data scoreboard, plus hand-written conflict, back-to-back, idle and reset sequences.
`timescale 1ns/1ps
module tb_k_and_s_mem_arbiter;

   typedef struct {
      logic        dbg;
      logic        we;
      logic [4:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [4:0]  cpu_addr, dbg_addr;
   logic [15:0] cpu_wdata, dbg_wdata;
   logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [15:0] cpu_rdata, dbg_rdata;
   logic [4:0]  ram_addr;
   logic [15:0] ram_wdata, ram_rdata;
   logic        ram_we;
   logic        ram_init;

   logic [15:0] mem [32];
   logic [15:0] cpu_q[$];
   logic [15:0] dbg_q[$];
   logic        gnt_log[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;

   k_and_s_mem_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .dbg_req    (dbg_req),
      .dbg_we     (dbg_we),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_gnt    (dbg_gnt),
      .dbg_rvalid (dbg_rvalid),
      .dbg_rdata  (dbg_rdata),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_we     (ram_we),
      .ram_rdata  (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: synchronous write, read data valid one cycle after address.
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= (i == 3) ? 16'hBEEF : (16'hA000 | 16'(i));
      end else if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle monitor: grant log, overlap check and read-data scoreboard.
   task automatic monitor();
      if (cpu_gnt && dbg_gnt) chk("gnt_overlap", {cpu_gnt, dbg_gnt}, 2'b00);
      if (cpu_gnt) gnt_log.push_back(1'b0);
      if (dbg_gnt) gnt_log.push_back(1'b1);
      if (cpu_rvalid) begin
         if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", cpu_rvalid, 1'b0);
         else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end
      if (dbg_rvalid) begin
         if (dbg_q.size() == 0) chk("dbg_rvalid_unexpected", dbg_rvalid, 1'b0);
         else chk("dbg_rdata", dbg_rdata, dbg_q.pop_front());
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      monitor();
   endtask

   // One uncontended access; entered and left 1 ns after a clock edge with the DUT in IDLE.
   task automatic access(input logic dbg, input logic we, input logic [4:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_rdata,
                         output int gnt_cyc);
      int   n;
      logic g;
      if (dbg) begin
         dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
         if (!we) dbg_q.push_back(exp_rdata);
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
         if (!we) cpu_q.push_back(exp_rdata);
      end
      n = 0;
      g = 1'b0;
      while (!g && n < 20) begin
         step();
         n++;
         g = dbg ? dbg_gnt : cpu_gnt;
      end
      gnt_cyc = cyc;
      chk("gnt_latency", n, 1);
      chk("ram_addr", ram_addr, addr);
      chk("ram_we", ram_we, we);
      if (we) chk("ram_wdata", ram_wdata, wdata);
      step();
      if (dbg) dbg_req = 1'b0;
      else cpu_req = 1'b0;
      chk("ram_we_one_cycle", ram_we, 1'b0);
      chk("rvalid_timing", dbg ? dbg_rvalid : cpu_rvalid, !we);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        tbl [9];
      logic        exp_pat [10];
      int          gc [3];
      int          gdummy;
      int          n;
      logic [4:0]  hold_addr;

      tbl[0] = '{1'b0, 1'b0, 5'h03, 16'h0000, 16'hBEEF};
      tbl[1] = '{1'b1, 1'b1, 5'h1F, 16'h1234, 16'h0000};
      tbl[2] = '{1'b0, 1'b0, 5'h1F, 16'h0000, 16'h1234};
      tbl[3] = '{1'b1, 1'b0, 5'h03, 16'h0000, 16'hBEEF};
      tbl[4] = '{1'b0, 1'b1, 5'h0A, 16'h5A5A, 16'h0000};
      tbl[5] = '{1'b1, 1'b0, 5'h0A, 16'h0000, 16'h5A5A};
      tbl[6] = '{1'b0, 1'b0, 5'h07, 16'h0000, 16'hA007};
      tbl[7] = '{1'b1, 1'b1, 5'h00, 16'hFFFF, 16'h0000};
      tbl[8] = '{1'b0, 1'b0, 5'h00, 16'h0000, 16'hFFFF};
      exp_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      rst_n = 1'b0; ram_init = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 5'h00; cpu_wdata = 16'h0000;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'h00; dbg_wdata = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, ram_we, ram_addr, ram_wdata},
          26'd0);
      @(negedge clk);
      rst_n = 1'b1; ram_init = 1'b0;
      step();

      // Single accesses from the table, each issued in the cycle after the previous grant.
      for (int i = 0; i < 9; i++)
         access(tbl[i].dbg, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, gdummy);

      // Back-to-back CPU reads: grants two cycles apart, data in address order.
      access(1'b0, 1'b0, 5'h00, 16'h0000, 16'hFFFF, gc[0]);
      access(1'b0, 1'b0, 5'h01, 16'h0000, 16'hA001, gc[1]);
      access(1'b0, 1'b0, 5'h02, 16'h0000, 16'hA002, gc[2]);
      chk("b2b_gap1", gc[1] - gc[0], 2);
      chk("b2b_gap2", gc[2] - gc[1], 2);

      // Conflict: both requesters held, expect C,C,C,C,D,C,C,C,C,D.
      gnt_log.delete();
      cpu_we = 1'b1; cpu_addr = 5'h10; cpu_wdata = 16'hC0C0;
      dbg_we = 1'b1; dbg_addr = 5'h11; dbg_wdata = 16'hD0D0;
      cpu_req = 1'b1; dbg_req = 1'b1;
      n = 0;
      while (gnt_log.size() < 10 && n < 60) begin
         step();
         n++;
      end
      step();
      dbg_req = 1'b0;
      n = 0;
      while (!cpu_gnt && n < 10) begin
         step();
         n++;
      end
      step();
      cpu_req = 1'b0;
      chk("conflict_grants", gnt_log.size(), 11);
      for (int k = 0; k < 10; k++)
         if (k < gnt_log.size()) chk("conflict_order", gnt_log[k], exp_pat[k]);
      if (gnt_log.size() > 10) chk("conflict_tail", gnt_log[10], 1'b0);

      // Idle hold: nothing requested, RAM outputs must sit still.
      hold_addr = ram_addr;
      chk("idle_addr_start", ram_addr, 5'h10);
      for (int k = 0; k < 10; k++) begin
         step();
         chk("idle_hold", {ram_we, ram_addr, cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid},
             {1'b0, hold_addr, 4'b0000});
      end

      // Async reset in the middle of a CPU read: outputs clear at once, no rvalid afterwards.
      cpu_we = 1'b0; cpu_addr = 5'h03; cpu_wdata = 16'h7777; cpu_req = 1'b1;
      n = 0;
      while (!cpu_gnt && n < 20) begin
         step();
         n++;
      end
      chk("rst_pre_gnt", cpu_gnt, 1'b1);
      chk("rst_pre_addr", ram_addr, 5'h03);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_outputs", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, ram_we, ram_addr, ram_wdata},
          26'd0);
      cpu_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("rst_no_rvalid", {cpu_rvalid, cpu_gnt}, 2'b00);
      end

      chk("scoreboard_empty", cpu_q.size() + dbg_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
